unit_output: RTL

Transmit side of the unit's narrow packet bus: on request, reads a thread's result words from unit main memory and serializes them to the arbiter over `UNIT_OUTPUT_WIDTH`-bit chunks. Frames the packet as a header chunk, then data, with `ctrl` marking the header and the last data chunk; this is the framing the input side already uses. After the last chunk it writes `THREAD_STATE_NONE` to the thread-state memory so the thread can be reused. Sits between the unit's cores/memory and the arbiter's unit-output collector.

---
 rtl/unit_output.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/unit_output.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : unit_output
// Purpose  : Transmit side of the unit's narrow packet bus. Accepts an output
//            request, prefetches the thread's result words from unit memory
//            through a 2-entry FIFO, and serializes them as a header chunk
//            followed by RATIO chunks per word (LSB chunk first). ctrl marks
//            the header and the final data chunk. When the packet is done the
//            thread-state memory is written with THREAD_STATE_NONE.
// Ports    : CLK, RST_N            clock / async active-low reset
//            req, req_thread, req_addr, req_len, req_type, req_ack, busy
//                                  request handshake (len 0 = 32 words)
//            mem_addr, mem_rd_en, mem_dout
//                                  memory read port, 1-cycle read latency
//            dout, wr_en, ctrl, full
//                                  chunk stream to the arbiter
//            ts_num, ts_wr_en, ts_wr
//                                  thread-state write port
// Revision : 1.0  initial release
// ============================================================================
module unit_output #(
   parameter int N_THREADS      = 8,
   parameter int OUTPUT_WIDTH   = 16,
   parameter int MEM_ADDR_W     = 8,
   parameter int THREAD_STATE_W = 2,
   parameter logic [THREAD_STATE_W-1:0] THREAD_STATE_NONE = '0
) (
   input  logic                                     CLK,
   input  logic                                     RST_N,
   input  logic                                     req,
   input  logic [$clog2(N_THREADS)-1:0]             req_thread,
   input  logic [MEM_ADDR_W-1:0]                    req_addr,
   input  logic [4:0]                               req_len,
   input  logic [2:0]                               req_type,
   output logic                                     req_ack,
   output logic                                     busy,
   output logic [$clog2(N_THREADS)+MEM_ADDR_W-1:0]  mem_addr,
   output logic                                     mem_rd_en,
   input  logic [31:0]                              mem_dout,
   output logic [OUTPUT_WIDTH-1:0]                  dout,
   output logic                                     wr_en,
   output logic                                     ctrl,
   input  logic                                     full,
   output logic [$clog2(N_THREADS)-1:0]             ts_num,
   output logic                                     ts_wr_en,
   output logic [THREAD_STATE_W-1:0]                ts_wr
);

   localparam int TW    = $clog2(N_THREADS);
   localparam int RATIO = 32 / OUTPUT_WIDTH;
   localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] c_chunk_last = CW'(RATIO - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HEADER   = 3'd1,
      S_DATA     = 3'd2,
      S_TS_WRITE = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t                  r_state, w_next;

   logic [TW-1:0]           r_thread;
   logic [MEM_ADDR_W-1:0]   r_addr;
   logic [2:0]              r_type;
   logic [5:0]              r_rd_left;     // words still to be read
   logic [5:0]              r_wd_left;     // words still to be sent
   logic [CW-1:0]           r_chunk;
   logic                    r_ack;
   logic                    r_pend;        // read issued last cycle, data arrives now
   logic [31:0]             r_fifo [0:1];
   logic                    r_wp, r_rp;
   logic [1:0]              r_cnt;

   logic                    w_accept;
   logic                    w_rd_ok;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_last;
   logic [OUTPUT_WIDTH-1:0] w_hdr;
   logic [OUTPUT_WIDTH-1:0] w_chunk;

   // DONE accepts a new request too, so a held req restarts two edges after
   // the final chunk is taken.
   assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && req;
   assign w_rd_ok  = (({1'b0, r_cnt} + {2'b00, r_pend}) < 3'd2) && (r_rd_left != 6'd0);
   assign w_push   = r_pend;
   assign w_pop    = wr_en && (r_state == S_DATA) && (r_chunk == c_chunk_last);
   assign w_last   = (r_chunk == c_chunk_last) && (r_wd_left == 6'd1);
   assign w_chunk  = r_fifo[r_rp][r_chunk*OUTPUT_WIDTH +: OUTPUT_WIDTH];

   assign req_ack  = r_ack;
   assign mem_addr = {r_thread, r_addr};
   assign ts_wr    = THREAD_STATE_NONE;

   always_comb begin
      w_hdr          = '0;
      w_hdr[2:0]     = r_type;
      w_hdr[3 +: TW] = r_thread;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      busy      = 1'b0;
      mem_rd_en = 1'b0;
      dout      = '0;
      wr_en     = 1'b0;
      ctrl      = 1'b0;
      ts_wr_en  = 1'b0;
      ts_num    = '0;
      case (r_state)
         S_IDLE: begin
            if (req) w_next = S_HEADER;
         end
         S_HEADER: begin
            busy      = 1'b1;
            mem_rd_en = w_rd_ok;
            dout      = w_hdr;
            ctrl      = 1'b1;
            wr_en     = ~full;
            if (!full) w_next = S_DATA;
         end
         S_DATA: begin
            busy      = 1'b1;
            mem_rd_en = w_rd_ok;
            if (r_cnt != 2'd0) begin
               dout  = w_chunk;
               ctrl  = w_last;
               wr_en = ~full;
               if (!full && w_last) w_next = S_TS_WRITE;
            end
         end
         S_TS_WRITE: begin
            busy     = 1'b1;
            ts_wr_en = 1'b1;
            ts_num   = r_thread;
            w_next   = S_DONE;
         end
         S_DONE: begin
            w_next = req ? S_HEADER : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_thread  <= '0;
         r_addr    <= '0;
         r_type    <= '0;
         r_rd_left <= '0;
         r_wd_left <= '0;
         r_chunk   <= '0;
         r_ack     <= 1'b0;
         r_pend    <= 1'b0;
         r_wp      <= 1'b0;
         r_rp      <= 1'b0;
         r_cnt     <= 2'd0;
         for (int i = 0; i < 2; i++) r_fifo[i] <= '0;
      end else begin
         r_ack  <= w_accept;
         r_pend <= mem_rd_en;
         if (w_accept) begin
            r_thread  <= req_thread;
            r_addr    <= req_addr;
            r_type    <= req_type;
            // length 0 encodes 32 words
            r_rd_left <= {(req_len == 5'd0), req_len};
            r_wd_left <= {(req_len == 5'd0), req_len};
            r_chunk   <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_cnt     <= 2'd0;
         end else begin
            if (mem_rd_en) begin
               r_addr    <= r_addr + 1'b1;
               r_rd_left <= r_rd_left - 6'd1;
            end
            if (w_push) begin
               r_fifo[r_wp] <= mem_dout;
               r_wp         <= ~r_wp;
            end
            if (wr_en && (r_state == S_DATA)) begin
               if (r_chunk == c_chunk_last) begin
                  r_chunk   <= '0;
                  r_rp      <= ~r_rp;
                  r_wd_left <= r_wd_left - 6'd1;
               end else begin
                  r_chunk <= r_chunk + 1'b1;
               end
            end
            if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 2'd1;
         end
      end
   end

endmodule
`default_nettype wire
